// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults, FSM state type and ALU select codes for conv_mac_seq.
`default_nettype none

package conv_pkg;

    localparam int DEF_IMG_W = 4;
    localparam int DEF_KER_W = 2;
    localparam int DEF_ACC_W = 10;
    localparam int DATA_W    = 4;

    localparam logic [1:0] ALU_SEL_NONE = 2'b00;
    localparam logic [1:0] ALU_SEL_MUL  = 2'b01;
    localparam logic [1:0] ALU_SEL_ADD  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter/address width for n distinct values, never below 1 bit.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: window/tap counters producing pixel and kernel addresses.
`default_nettype none

module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int KER_W  = DEF_KER_W,
    parameter int PIX_AW = 4,
    parameter int KRN_AW = 2,
    parameter int WIN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_tap_adv,
    input  logic              i_win_adv,
    output logic [PIX_AW-1:0] o_pix_addr,
    output logic [KRN_AW-1:0] o_krn_addr,
    output logic [WIN_W-1:0]  o_win_idx,
    output logic              o_last_tap,
    output logic              o_last_win
);

    localparam int OUT_N = IMG_W - KER_W + 1;
    localparam int NWIN  = OUT_N * OUT_N;
    localparam int OW    = cw(OUT_N);
    localparam int TW    = cw(KER_W);

    logic [OW-1:0]    r_wr;
    logic [OW-1:0]    r_wc;
    logic [TW-1:0]    r_tr;
    logic [TW-1:0]    r_tc;
    logic [WIN_W-1:0] r_win;

    logic w_last_tc;
    logic w_last_wc;

    assign w_last_tc  = (r_tc == TW'(KER_W - 1));
    assign w_last_wc  = (r_wc == OW'(OUT_N - 1));
    assign o_last_tap = w_last_tc && (r_tr == TW'(KER_W - 1));
    assign o_last_win = (r_win == WIN_W'(NWIN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tr <= '0;
            r_tc <= '0;
        end else if (i_clear) begin
            r_tr <= '0;
            r_tc <= '0;
        end else if (i_tap_adv) begin
            if (w_last_tc) begin
                r_tc <= '0;
                r_tr <= o_last_tap ? '0 : r_tr + 1'b1;
            end else begin
                r_tc <= r_tc + 1'b1;
            end
        end
    end

    // Windows advance row-major across the valid output grid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_wc  <= '0;
            r_win <= '0;
        end else if (i_clear) begin
            r_wr  <= '0;
            r_wc  <= '0;
            r_win <= '0;
        end else if (i_win_adv) begin
            if (o_last_win) begin
                r_wr  <= '0;
                r_wc  <= '0;
                r_win <= '0;
            end else begin
                r_win <= r_win + 1'b1;
                if (w_last_wc) begin
                    r_wc <= '0;
                    r_wr <= r_wr + 1'b1;
                end else begin
                    r_wc <= r_wc + 1'b1;
                end
            end
        end
    end

    assign o_pix_addr = PIX_AW'((32'(r_wr) + 32'(r_tr)) * IMG_W + 32'(r_wc) + 32'(r_tc));
    assign o_krn_addr = KRN_AW'(32'(r_tr) * KER_W + 32'(r_tc));
    assign o_win_idx  = r_win;

endmodule

`default_nettype wire

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sequential valid 2D convolution on an external shared ALU.
// Optional macro CONV_MAC_SEQ_SAT8_EN saturates out_data to 255.
`default_nettype none

module conv_mac_seq
    import conv_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int KER_W = DEF_KER_W,
    parameter int ACC_W = DEF_ACC_W,
    localparam int PIX_AW = cw(IMG_W * IMG_W),
    localparam int KRN_AW = cw(KER_W * KER_W),
    localparam int WIN_W  = cw((IMG_W - KER_W + 1) * (IMG_W - KER_W + 1))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_we,
    input  logic [PIX_AW-1:0]   pix_addr,
    input  logic [DATA_W-1:0]   pix_data,
    input  logic                krn_we,
    input  logic [KRN_AW-1:0]   krn_addr,
    input  logic [DATA_W-1:0]   krn_data,
    input  logic                start,
    output logic                busy,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [1:0]          alu_sel,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic                out_valid,
    output logic [WIN_W-1:0]    out_idx,
    output logic [ACC_W-1:0]    out_data,
    output logic                done
);

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_pix [IMG_W*IMG_W];
    logic [DATA_W-1:0] r_krn [KER_W*KER_W];
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_out;

    logic              w_clear;
    logic              w_tap_adv;
    logic              w_win_adv;
    logic [PIX_AW-1:0] w_pix_addr;
    logic [KRN_AW-1:0] w_krn_addr;
    logic [WIN_W-1:0]  w_win_idx;
    logic              w_last_tap;
    logic              w_last_win;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .KER_W  (KER_W),
        .PIX_AW (PIX_AW),
        .KRN_AW (KRN_AW),
        .WIN_W  (WIN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_tap_adv  (w_tap_adv),
        .i_win_adv  (w_win_adv),
        .o_pix_addr (w_pix_addr),
        .o_krn_addr (w_krn_addr),
        .o_win_idx  (w_win_idx),
        .o_last_tap (w_last_tap),
        .o_last_win (w_last_win)
    );

    // Memories are writable only in IDLE so a run sees a stable image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_W * IMG_W; i++) begin
                r_pix[i] <= '0;
            end
        end else if (pix_we && (r_state == ST_IDLE)) begin
            r_pix[pix_addr] <= pix_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KER_W * KER_W; i++) begin
                r_krn[i] <= '0;
            end
        end else if (krn_we && (r_state == ST_IDLE)) begin
            r_krn[krn_addr] <= krn_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_tap_adv   = 1'b0;
        w_win_adv   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_sel     = ALU_SEL_NONE;
        out_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                w_tap_adv = 1'b1;
                alu_a     = r_pix[w_pix_addr];
                alu_b     = r_krn[w_krn_addr];
                alu_sel   = ALU_SEL_MUL;
                if (w_last_tap) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid   = 1'b1;
                w_win_adv   = 1'b1;
                w_state_nxt = w_last_win ? ST_DONE : ST_MUL;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_clear || (r_state == ST_EMIT)) begin
            r_acc <= '0;
        end else if (r_state == ST_MUL) begin
            r_acc <= r_acc + ACC_W'(alu_result);
        end
    end

`ifdef CONV_MAC_SEQ_SAT8_EN
    assign w_acc_out = (r_acc > ACC_W'(255)) ? ACC_W'(255) : r_acc;
`else
    assign w_acc_out = r_acc;
`endif

    assign out_idx  = out_valid ? w_win_idx : '0;
    assign out_data = out_valid ? w_acc_out : '0;

endmodule

`default_nettype wire
